// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the datapath instruction controller.
// Holds the FSM state encoding, opcode/op field values and the register
// file write-source select values used by datapath_ctrl and instr_dec.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_ALU    = 3'd5,
        S_WR_REG = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: combinational instruction decoder.
// Ports: ir (instruction word in); op, rn, rd, sh, rm (fields out);
// sximm8 (sign-extended imm8 out); is_* (instruction class flags out).
import ctrl_pkg::*;

module instr_dec #(
    parameter int DW = 16
) (
    input  logic [15:0]   ir,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [1:0]    sh,
    output logic [2:0]    rm,
    output logic [DW-1:0] sximm8,
    output logic          is_mov_imm,
    output logic          is_mov_reg,
    output logic          is_alu,
    output logic          is_cmp,
    output logic          is_mvn,
    output logic          is_undef
);

    logic [2:0] opcode_s;

    // Field split, immediate extension and instruction classification.
    always_comb begin
        opcode_s   = ir[15:13];
        op         = ir[12:11];
        rn         = ir[10:8];
        rd         = ir[7:5];
        sh         = ir[4:3];
        rm         = ir[2:0];
        sximm8     = {{(DW-8){ir[7]}}, ir[7:0]};
        is_mov_imm = (opcode_s == OPC_MOV) && (op == OP_MOV_IMM);
        is_mov_reg = (opcode_s == OPC_MOV) && (op == OP_MOV_REG);
        // is_alu covers the whole 101 group, including CMP and MVN
        is_alu     = (opcode_s == OPC_ALU);
        is_cmp     = is_alu && (op == OP_CMP);
        is_mvn     = is_alu && (op == OP_MVN);
        is_undef   = !(is_mov_imm || is_mov_reg || is_alu);
    end

endmodule

// File: rtl/vDFFE.sv
// vDFFE: n-bit register with load enable.
// Ports: clk (rising edge), en (load enable), d (next value), q (stored value).
module vDFFE #(
    parameter int n = 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    // Capture d when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (en) q <= d;
    end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle controller for the 8x16 register file/datapath.
// Inputs : clk, reset_n (sync, active low), in_instr, load, s.
// Outputs: w (idle), readnum/writenum/write (register file),
//          loada/loadb/loadc/loads/asel/vsel/shift/ALUop/sximm8 (datapath).
// Outputs are registered, computed from the next state and next IR so each
// register holds exactly the Moore decode of the current state and IR.
import ctrl_pkg::*;

module datapath_ctrl #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   in_instr,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] sximm8
);

    state_e        state_q, state_d;
    logic [15:0]   ir_q, ir_d, ir_load_s;
    logic          ir_en_s;

    logic [1:0]    op_s, sh_s;
    logic [2:0]    rn_s, rd_s, rm_s;
    logic [DW-1:0] sximm8_s;
    logic          is_mov_imm_s, is_mov_reg_s, is_alu_s;
    logic          is_cmp_s, is_mvn_s, is_undef_s;

    logic          w_q, w_d;
    logic [2:0]    readnum_q, readnum_d, writenum_q, writenum_d;
    logic          write_q, write_d, loada_q, loada_d, loadb_q, loadb_d;
    logic          loadc_q, loadc_d, loads_q, loads_d;
    logic          asel_q, asel_d, vsel_q, vsel_d;
    logic [1:0]    shift_q, shift_d, aluop_q, aluop_d;
    logic [DW-1:0] sximm8_q, sximm8_d;

    // IR enable/data: reset clears it, otherwise only WAIT with load writes it.
    always_comb begin
        ir_en_s   = !reset_n || ((state_q == S_WAIT) && load);
        ir_load_s = reset_n ? in_instr : 16'd0;
        ir_d      = ir_en_s ? ir_load_s : ir_q;
    end

    vDFFE #(.n(16)) u_ir (
        .clk (clk),
        .en  (ir_en_s),
        .d   (ir_load_s),
        .q   (ir_q)
    );

    // Decode the next IR so the registered outputs line up with it.
    instr_dec #(.DW(DW)) u_dec (
        .ir         (ir_d),
        .op         (op_s),
        .rn         (rn_s),
        .rd         (rd_s),
        .sh         (sh_s),
        .rm         (rm_s),
        .sximm8     (sximm8_s),
        .is_mov_imm (is_mov_imm_s),
        .is_mov_reg (is_mov_reg_s),
        .is_alu     (is_alu_s),
        .is_cmp     (is_cmp_s),
        .is_mvn     (is_mvn_s),
        .is_undef   (is_undef_s)
    );

    // Next-state logic; IR is stable outside WAIT so ir_d equals ir_q there.
    always_comb begin
        state_d = state_q;
        if (!reset_n) begin
            state_d = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
                S_DECODE: begin
                    if (is_mov_imm_s)                      state_d = S_WR_IMM;
                    else if (is_mov_reg_s || is_mvn_s)     state_d = S_GET_B;
                    else if (is_alu_s)                     state_d = S_GET_A;
                    else                                   state_d = S_WAIT;
                end
                S_WR_IMM: state_d = S_WAIT;
                S_GET_A:  state_d = S_GET_B;
                S_GET_B:  state_d = S_ALU;
                S_ALU:    state_d = is_cmp_s ? S_WAIT : S_WR_REG;
                S_WR_REG: state_d = S_WAIT;
                default:  state_d = S_WAIT;
            endcase
        end
    end

    // Output decode from the next state and next IR fields.
    always_comb begin
        w_d        = 1'b0;
        readnum_d  = 3'd0;
        writenum_d = 3'd0;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        vsel_d     = VSEL_C;
        asel_d     = is_mov_reg_s;
        shift_d    = (is_mov_imm_s || is_undef_s) ? 2'b00 : sh_s;
        aluop_d    = is_alu_s ? op_s : 2'b00;
        sximm8_d   = sximm8_s;
        case (state_d)
            S_WAIT:   w_d = 1'b1;
            S_DECODE: w_d = 1'b0;
            S_WR_IMM: begin
                writenum_d = rn_s;
                write_d    = 1'b1;
                vsel_d     = VSEL_IMM;
            end
            S_GET_A: begin
                readnum_d = rn_s;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm_s;
                loadb_d   = 1'b1;
            end
            S_ALU: begin
                loads_d = is_cmp_s;
                loadc_d = !is_cmp_s;
            end
            S_WR_REG: begin
                writenum_d = rd_s;
                write_d    = 1'b1;
                vsel_d     = VSEL_C;
            end
            default:  w_d = 1'b1;
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            w_q        <= 1'b1;
            readnum_q  <= 3'd0;
            writenum_q <= 3'd0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            vsel_q     <= VSEL_C;
            shift_q    <= 2'b00;
            aluop_q    <= 2'b00;
            sximm8_q   <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            asel_q     <= asel_d;
            vsel_q     <= vsel_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
            sximm8_q   <= sximm8_d;
        end
    end

    assign w        = w_q;
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign vsel     = vsel_q;
    assign shift    = shift_q;
    assign ALUop    = aluop_q;
    assign sximm8   = sximm8_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed plus randomized bench for datapath_ctrl.
// The reference model expands each started instruction into its list of
// per-cycle expected output vectors and compares the DUT every cycle.
module tb_datapath_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n, load, s;
    logic [15:0]   in_instr;
    logic          w, write, loada, loadb, loadc, loads, asel, vsel;
    logic [2:0]    readnum, writenum;
    logic [1:0]    shift, ALUop;
    logic [DW-1:0] sximm8;

    always #5 clk = ~clk;

    datapath_ctrl #(.DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_instr (in_instr),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8)
    );

    typedef struct packed {
        logic          w;
        logic [2:0]    readnum;
        logic [2:0]    writenum;
        logic          write;
        logic          loada;
        logic          loadb;
        logic          loadc;
        logic          loads;
        logic          asel;
        logic          vsel;
        logic [1:0]    shift;
        logic [1:0]    aluop;
        logic [DW-1:0] sximm8;
    } outs_t;

    outs_t obs;
    assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, vsel, shift, ALUop, sximm8};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_ir;
    bit          m_wait;
    outs_t       m_exp;
    outs_t       exp_q[$];

    // Fields that hold in every cycle for a given IR (strobes off, busy).
    function automatic outs_t base(input logic [15:0] ir);
        outs_t o;
        logic  mov_reg, alu;
        mov_reg  = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
        alu      = (ir[15:13] == 3'b101);
        o        = '0;
        o.shift  = (mov_reg || alu) ? ir[4:3] : 2'b00;
        o.aluop  = alu ? ir[12:11] : 2'b00;
        o.asel   = mov_reg;
        o.sximm8 = DW'($signed(ir[7:0]));
        return o;
    endfunction

    // Expand one started instruction into its sequence of busy cycles.
    function automatic void plan(input logic [15:0] ir);
        outs_t o, c;
        logic  mov_imm, mov_reg, alu, cmp, mvn;
        mov_imm = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
        mov_reg = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
        alu     = (ir[15:13] == 3'b101);
        cmp     = alu && (ir[12:11] == 2'b01);
        mvn     = alu && (ir[12:11] == 2'b11);
        o = base(ir);
        exp_q.push_back(o);
        if (mov_imm) begin
            c = o; c.writenum = ir[10:8]; c.write = 1'b1; c.vsel = 1'b1;
            exp_q.push_back(c);
        end else if (mov_reg || alu) begin
            if (!(mov_reg || mvn)) begin
                c = o; c.readnum = ir[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = o; c.readnum = ir[2:0]; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = o;
            if (cmp) c.loads = 1'b1; else c.loadc = 1'b1;
            exp_q.push_back(c);
            if (!cmp) begin
                c = o; c.writenum = ir[7:5]; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        if (!reset_n) begin
            m_ir = 16'd0;
            exp_q.delete();
        end else if (m_wait) begin
            if (load) m_ir = in_instr;
            if (s) plan(m_ir);
        end
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_wait = 1'b0;
        end else begin
            m_exp   = base(m_ir);
            m_exp.w = 1'b1;
            m_wait  = 1'b1;
        end
    endtask

    task automatic cyc(input logic rn, input logic ld, input logic st,
                       input logic [15:0] ins, input string tag);
        reset_n  = rn;
        load     = ld;
        s        = st;
        in_instr = ins;
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        assert (obs === m_exp) else begin
            errors++;
            $error("FAIL %s: outputs got %h expected %h", tag, obs, m_exp);
        end
        checks++;
        assert (!(obs.write && (obs.loada || obs.loadb)) && !$isunknown(obs)) else begin
            errors++;
            $error("FAIL %s_consistency: outputs got %h expected no write with loada/loadb", tag, obs);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Start an instruction and measure busy cycles and write pulses.
    task automatic run_instr(input logic [15:0] ins, input string tag, input int lat);
        int busy   = 0;
        int writes = 0;
        cyc(1'b1, 1'b1, 1'b1, ins, tag);
        for (int i = 0; i < 12 && w !== 1'b1; i++) begin
            busy++;
            if (write === 1'b1) writes++;
            cyc(1'b1, 1'b0, 1'b0, ins, tag);
        end
        chk_val({tag, "_latency"}, 32'(busy), 32'(lat));
        chk_val({tag, "_writes"}, 32'(writes > 1), 32'd0);
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 6))
            0:       r[15:11] = 5'b11010;
            1:       r[15:11] = 5'b11000;
            2, 3, 4: r[15:13] = 3'b101;
            5:       r[15:13] = 3'b101;
            default: r = r;
        endcase
        return r;
    endfunction

    initial begin
        m_ir   = 16'd0;
        m_wait = 1'b1;
        m_exp  = '0;

        // Reset with load and s held high: IR must stay 0.
        cyc(1'b0, 1'b1, 1'b1, 16'hD3FE, "reset1");
        cyc(1'b0, 1'b1, 1'b1, 16'hD3FE, "reset2");
        chk_val("reset_w_sximm8", {w, 15'd0, sximm8}, {1'b1, 15'd0, 16'h0000});

        // MOV R3,#-2 step by step.
        cyc(1'b1, 1'b1, 1'b1, 16'hD3FE, "movi_decode");
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, "movi_wr");
        chk_val("movi_sximm8", 32'(sximm8), 32'h0000_FFFE);
        chk_val("movi_write", {27'd0, write, writenum, vsel}, {27'd0, 1'b1, 3'd3, 1'b1});
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, "movi_done");
        chk_val("movi_idle", 32'(w), 32'd1);

        // Latency of each instruction class.
        run_instr(16'hA148, "add", 5);
        run_instr(16'hAD06, "cmp", 4);
        run_instr(16'hC0F4, "movr", 4);
        run_instr(16'hB7E9, "and", 5);
        run_instr(16'hBB2A, "mvn", 4);
        run_instr(16'hD3FE, "movi", 2);
        run_instr(16'h0000, "undef", 1);
        run_instr(16'hFFFF, "undef2", 1);

        // load during an ADD is ignored and the ADD completes.
        cyc(1'b1, 1'b1, 1'b1, 16'hA148, "ldbusy_start");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 16'hFFFF, "ldbusy");
        chk_val("ldbusy_ir_kept", {15'd0, w, sximm8}, {15'd0, 1'b1, 16'h0048});

        // Reset at the edge ending GET_B abandons the ADD.
        cyc(1'b1, 1'b1, 1'b1, 16'hA148, "rstmid_start");
        cyc(1'b1, 1'b0, 1'b0, 16'hA148, "rstmid_geta");
        cyc(1'b1, 1'b0, 1'b0, 16'hA148, "rstmid_getb");
        cyc(1'b0, 1'b0, 1'b0, 16'hA148, "rstmid_reset");
        chk_val("rstmid_idle", {28'd0, w, write, loadc, loads}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, "rstmid_after");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), gen_instr(), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Multi-cycle instruction controller that sits directly upstream of the 8x16 register file and datapath. It latches a 16-bit instruction and sequences one instruction per start pulse. On each cycle it drives the register file ports (readnum, writenum, write) and the datapath strobes (loada, loadb, loadc, loads, asel, vsel, shift, ALUop, sximm8). It reports idle through w.

Parameters:
DW, 16, datapath width; sximm8 is sign-extended to DW bits.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_instr  input  16  instruction word
load  input  1  capture in_instr into IR (honoured only in WAIT)
s  input  1  start execution (sampled only in WAIT)
w  output  1  1 = idle in WAIT
readnum  output  3  register file read index
writenum  output  3  register file write index
write  output  1  register file write enable
loada  output  1  load A operand register
loadb  output  1  load B operand register
loadc  output  1  load C result register
loads  output  1  load status flags
asel  output  1  1 = force ALU A input to 0
vsel  output  1  register file write source: 0 = C, 1 = sximm8
shift  output  2  shifter op
ALUop  output  2  ALU op
sximm8  output  DW  sign-extended IR[7:0]

Behaviour:
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0], imm8 = IR[7:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
  - Anything else is undefined.
- State register and IR update on the rising clk edge. All outputs are Moore, decoded from the registered state and IR only.
- Reset:
  - reset_n=0 at an edge puts the FSM in WAIT and sets IR=0.
  - Reset has priority over load and s, and applies in any state. Mid-instruction, the remaining cycles are abandoned and no further write is issued.
  - Reset output values: w=1, every strobe 0, readnum=writenum=0, shift=0, ALUop=0, sximm8=0.
- IR load:
  - IR loads only when state==WAIT and load=1.
  - load is ignored in any other state.
  - If load=1 and s=1 in the same WAIT cycle, the new word is captured and executed.
- States and transitions:
  - WAIT: w=1. If s=1, go to DECODE; else stay.
  - DECODE: MOV imm goes to WR_IMM. MOV reg and MVN go to GET_B. ADD, CMP and AND go to GET_A. Undefined goes to WAIT with no strobes.
  - WR_IMM: writenum=Rn, write=1, vsel=1. Next state WAIT.
  - GET_A: readnum=Rn, loada=1. Next state GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state ALU.
  - ALU, for CMP: loads=1, loadc=0, next state WAIT.
  - ALU, for all others: loadc=1, next state WR_REG.
  - WR_REG: writenum=Rd, write=1, vsel=0. Next state WAIT.
- Field outputs:
  - shift = sh in every state, except 0 for MOV imm and undefined.
  - ALUop = op for opcode 101, 00 for MOV reg.
  - asel = 1 for MOV reg, else 0.
  - readnum and writenum are 0 in states that do not name them.
  - sximm8 = {{(DW-8){imm8[7]}}, imm8}, driven continuously from IR.
- Latency (number of non-WAIT cycles, w=0):
  - MOV imm: 2
  - ADD, AND: 5
  - MOV reg, MVN, CMP: 4
  - undefined: 1
- write is asserted for at most one cycle per instruction. Strobes are mutually consistent: never write together with loada or loadb.

Decomposition:
- Shared package (ctrl_pkg) holds:
  - state encoding constants for WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG (3-bit)
  - opcode/op constants
  - VSEL_C=0, VSEL_IMM=1
- IR is built on the team's enable register vDFFE #(16).
- One natural sub-module: instr_dec, which is combinational. It splits IR into fields, produces sximm8, and classifies the instruction (is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_undef).

Test Plan:
1. Reset: hold reset_n=0 for 2 edges with s=1 and load=1 -> w=1, all strobes 0, sximm8=0; IR stays 0.
2. MOV R3,#-2: in_instr=16'hD3FE with load=s=1 -> DECODE, then WR_IMM (write=1, writenum=3, vsel=1, sximm8=16'hFFFE), w=1 on the 3rd cycle.
3. ADD R2,R1,R0,LSL#1: in_instr=16'hA148 -> GET_A (readnum=1, loada), GET_B (readnum=0, loadb), ALU (ALUop=00, shift=01, loadc), WR_REG (writenum=2, write, vsel=0); w=0 for 5 cycles.
4. CMP R5,R6: in_instr=16'hAD06 -> ALU cycle has loads=1 and loadc=0; write never asserted; w=0 for 4 cycles. Also MOV R7,R4,LSR: 16'hC0F4 -> GET_B readnum=4, then ALU with asel=1 and shift=10, then writenum=7.
5. Undefined 16'h0000 -> one DECODE cycle, then WAIT with no strobes. During an ADD, pulse load with 16'hFFFF -> IR unchanged and the ADD completes normally.
6. Reset mid-op: reset_n=0 at the edge ending GET_B -> WAIT next cycle, loadc and write never asserted.
